// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multi-cycle RISC-V style datapath.
// One instruction moves through FETCH -> DECODE -> EXEC -> MEM -> WB.
// NOP and illegal opcodes retire in DECODE. Branches retire in EXEC,
// stores retire in MEM, and R/I/load retire in WB.
// A memory request that waits TIMEOUT cycles without an ack moves the
// FSM to FAULT. Only rst leaves FAULT.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   inst[31:0]            instruction register contents (written by ir_we)
//   status[3:0]           ALU flags: [0]=zero, [1]=less-than
//   imem_req / imem_ack   instruction fetch handshake
//   dmem_req / dmem_we /  data access handshake (we: 1=store, 0=load)
//   dmem_ack
//   ir_we, pc_we, rw      one-cycle strobes: IR, PC and register-file write
//   alusrc, wb, pcsrc     ALU B=imm, writeback from memory, PC=branch target
//   imm_sel[1:0]          00 I, 01 load, 10 store, 11 branch
//   alu_op[3:0]           ALU operation code
//   illegal               one-cycle pulse on an unknown opcode
//   fault                 sticky memory-timeout flag
//   instret[31:0]         retired-instruction counter
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [3:0]  status,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rw,
    output logic        alusrc,
    output logic        wb,
    output logic        pcsrc,
    output logic [1:0]  imm_sel,
    output logic [3:0]  alu_op,
    output logic        illegal,
    output logic        fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_R, C_I, C_LD, C_ST, C_BR, C_ILL
    } cls_t;

    state_t      state;
    logic [7:0]  wcnt;
    logic [31:0] cnt;

    cls_t        cls;
    logic        d_alusrc, d_wb, taken;
    logic [1:0]  d_imm;
    logic [3:0]  d_aluop;
    logic [2:0]  f3;

    // These bits do not affect control.
    logic unused_bits;
    assign unused_bits = ^{inst[31], inst[29:15], inst[11:7], status[3:2]};

    assign f3 = inst[14:12];

    // The IR only changes on ir_we, so inst stays stable from DECODE to the
    // end of the instruction. Decoding it combinationally in every state
    // is therefore safe.
    always_comb begin
        cls      = C_ILL;
        d_alusrc = 1'b0;
        d_wb     = 1'b0;
        d_imm    = 2'b00;
        d_aluop  = 4'b0000;
        case (inst[6:0])
            7'b0110011: begin
                cls     = C_R;
                d_aluop = {inst[30], f3};
            end
            7'b0010011: begin
                cls      = C_I;
                d_alusrc = 1'b1;
                // Only the shift-right form uses inst[30] as a sub-op bit.
                // For the other I-types, that bit is part of the immediate.
                d_aluop  = {inst[30] & (f3 == 3'b101), f3};
            end
            7'b0000011: begin
                cls      = C_LD;
                d_alusrc = 1'b1;
                d_wb     = 1'b1;
                d_imm    = 2'b01;
            end
            7'b0100011: begin
                cls      = C_ST;
                d_alusrc = 1'b1;
                d_imm    = 2'b10;
            end
            7'b1100011: begin
                cls     = C_BR;
                d_imm   = 2'b11;
                d_aluop = 4'b1000;
            end
            7'b0000000: cls = C_NOP;
            default:    cls = C_ILL;
        endcase
    end

    // Only beq (000) and blt (100) can be taken.
    assign taken = ((f3 == 3'b000) & status[0]) | ((f3 == 3'b100) & status[1]);

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        rw       = 1'b0;
        alusrc   = 1'b0;
        wb       = 1'b0;
        pcsrc    = 1'b0;
        imm_sel  = 2'b00;
        alu_op   = 4'b0000;
        illegal  = 1'b0;
        fault    = 1'b0;
        if (!rst) begin
            if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
                alusrc  = d_alusrc;
                wb      = d_wb;
                imm_sel = d_imm;
                alu_op  = d_aluop;
            end
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_DECODE: begin
                    pc_we   = (cls == C_NOP) | (cls == C_ILL);
                    illegal = (cls == C_ILL);
                end
                S_EXEC: begin
                    if (cls == C_BR) begin
                        pc_we = 1'b1;
                        pcsrc = taken;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls == C_ST);
                    pc_we    = dmem_ack & (cls == C_ST);
                end
                S_WB: begin
                    rw    = 1'b1;
                    pc_we = 1'b1;
                end
                S_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign instret = rst ? 32'd0 : cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            wcnt  <= '0;
            cnt   <= '0;
        end else begin
            if (pc_we) cnt <= cnt + 32'd1;
            // Every path except an unacked wait clears the counter. This
            // gives a fresh count on each entry to FETCH or MEM.
            wcnt <= '0;
            case (state)
                S_FETCH: begin
                    if (imem_ack)                        state <= S_DECODE;
                    else if (wcnt == 8'(TIMEOUT - 1))    state <= S_FAULT;
                    else                                 wcnt  <= wcnt + 8'd1;
                end
                S_DECODE: begin
                    if (cls == C_NOP || cls == C_ILL) state <= S_FETCH;
                    else                              state <= S_EXEC;
                end
                S_EXEC: begin
                    case (cls)
                        C_BR:        state <= S_FETCH;
                        C_LD, C_ST:  state <= S_MEM;
                        default:     state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack)                        state <= (cls == C_LD) ? S_WB : S_FETCH;
                    else if (wcnt == 8'(TIMEOUT - 1))    state <= S_FAULT;
                    else                                 wcnt  <= wcnt + 8'd1;
                end
                S_WB:    state <= S_FETCH;
                S_FAULT: state <= S_FAULT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
